// File: rtl/aibcr3_str_align_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aibcr3_str_align_pkg                                          |
// | Purpose  : Shared state encoding, counter widths and helpers for the     |
// |            strobe-DLL alignment sequencer.                               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package aibcr3_str_align_pkg;

  // Width of the lock-wait timeout counter.
  localparam int c_tmo_w   = 12;
  // Width of the relock attempt counter.
  localparam int c_retry_w = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRST   = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_RETRY  = 3'd5,
    ST_FAIL   = 3'd6
  } seq_state_e;

  // A programmed hold length of zero still holds the DLL in reset for one clock.
  function automatic logic [3:0] hold_len(input logic [3:0] cyc);
    return (cyc == 4'd0) ? 4'd1 : cyc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aibcr3_sync_bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aibcr3_sync_bit                                               |
// | Purpose  : Single-bit flop synchronizer of configurable depth.           |
// | Ports    : clk  - destination clock                                      |
// |            rst  - synchronous active-high reset, clears all stages       |
// |            d_i  - asynchronous input bit                                 |
// |            q_o  - synchronized output (last stage)                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module aibcr3_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/aibcr3_str_align_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aibcr3_str_align_seq                                          |
// | Purpose  : Strobe-DLL alignment sequencer: resets the DLL, requests lock,|
// |            waits with timeout, filters lock glitches, retries, fails.    |
// | Ports    : clk_pll       - sole clock                                    |
// |            sync_rst      - synchronous active-high reset                 |
// |            seq_en        - 1 runs the sequence, 0 returns to IDLE        |
// |            csr_rst_cyc   - DLL reset hold length (0 treated as 1)        |
// |            csr_timeout   - lock wait limit in 2^TO_SHIFT units, 0=never  |
// |            csr_max_retry - relock attempts allowed after the first       |
// |            dll_lock      - asynchronous DLL lock status                  |
// |            code_valid    - synchronous DLL code valid                    |
// |            dll_rst_n     - active-low DLL reset                          |
// |            lock_req      - lock request to the DLL                       |
// |            align_done    - alignment achieved                            |
// |            align_fail    - retries exhausted (sticky)                    |
// |            retry_cnt     - relock attempts used                          |
// |            seq_state     - current state encoding                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module aibcr3_str_align_seq
  import aibcr3_str_align_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TO_SHIFT    = 4
) (
  input  logic                 clk_pll,
  input  logic                 sync_rst,
  input  logic                 seq_en,
  input  logic [3:0]           csr_rst_cyc,
  input  logic [7:0]           csr_timeout,
  input  logic [c_retry_w-1:0] csr_max_retry,
  input  logic                 dll_lock,
  input  logic                 code_valid,
  output logic                 dll_rst_n,
  output logic                 lock_req,
  output logic                 align_done,
  output logic                 align_fail,
  output logic [c_retry_w-1:0] retry_cnt,
  output logic [2:0]           seq_state
);

  logic lock_s;

  aibcr3_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk_pll),
    .rst (sync_rst),
    .d_i (dll_lock),
    .q_o (lock_s)
  );

  seq_state_e           state_q, state_d;
  logic [3:0]           hold_q, hold_d;
  logic [c_tmo_w-1:0]   tmo_q, tmo_d;
  logic                 drop_q, drop_d;
  logic [c_retry_w-1:0] retry_q, retry_d;
  logic                 dll_rst_n_q, dll_rst_n_d;
  logic                 lock_req_q, lock_req_d;
  logic                 align_done_q, align_done_d;
  logic                 align_fail_q, align_fail_d;

  logic [c_tmo_w-1:0]   tmo_limit;
  logic [c_tmo_w-1:0]   tmo_inc;

  assign tmo_limit = c_tmo_w'({{c_tmo_w{1'b0}}, csr_timeout} << TO_SHIFT);
  // Compare against the incremented value so WAIT lasts exactly limit clocks.
  assign tmo_inc   = tmo_q + c_tmo_w'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    drop_d  = 1'b0;   // drop history only survives while staying in LOCKED
    retry_d = retry_q;

    if (!seq_en) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DRST;
          hold_d  = hold_len(csr_rst_cyc);
        end
        ST_DRST: begin
          if (hold_q <= 4'd1) begin
            state_d = ST_REQ;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
        ST_REQ: begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end
        ST_WAIT: begin
          tmo_d = tmo_inc;
          // Lock takes priority over a coincident timeout.
          if (lock_s && code_valid) begin
            state_d = ST_LOCKED;
          end else if ((csr_timeout != 8'd0) && (tmo_inc == tmo_limit)) begin
            state_d = ST_RETRY;
          end
        end
        ST_LOCKED: begin
          if (!lock_s) begin
            if (drop_q) begin
              state_d = ST_RETRY;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
        ST_RETRY: begin
          if (retry_q < csr_max_retry) begin
            retry_d = (retry_q == '1) ? retry_q : retry_q + c_retry_w'(1);
            state_d = ST_DRST;
            hold_d  = hold_len(csr_rst_cyc);
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register with the state.
    dll_rst_n_d  = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_LOCKED);
    lock_req_d   = dll_rst_n_d;
    align_done_d = (state_d == ST_LOCKED);
    align_fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_pll) begin
    if (sync_rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      tmo_q        <= '0;
      drop_q       <= 1'b0;
      retry_q      <= '0;
      dll_rst_n_q  <= 1'b0;
      lock_req_q   <= 1'b0;
      align_done_q <= 1'b0;
      align_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      drop_q       <= drop_d;
      retry_q      <= retry_d;
      dll_rst_n_q  <= dll_rst_n_d;
      lock_req_q   <= lock_req_d;
      align_done_q <= align_done_d;
      align_fail_q <= align_fail_d;
    end
  end

  assign dll_rst_n  = dll_rst_n_q;
  assign lock_req   = lock_req_q;
  assign align_done = align_done_q;
  assign align_fail = align_fail_q;
  assign retry_cnt  = retry_q;
  assign seq_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_aibcr3_str_align_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aibcr3_str_align_seq                                       |
// | Purpose  : Self-checking bench: behavioural model compared every cycle,  |
// |            directed scenarios with literal expectations, random phase.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_aibcr3_str_align_seq;

  localparam int SYNC_STAGES = 2;
  localparam int TO_SHIFT    = 4;

  logic       clk_pll = 1'b0;
  logic       sync_rst;
  logic       seq_en;
  logic [3:0] csr_rst_cyc;
  logic [7:0] csr_timeout;
  logic [1:0] csr_max_retry;
  logic       dll_lock;
  logic       code_valid;
  logic       dll_rst_n;
  logic       lock_req;
  logic       align_done;
  logic       align_fail;
  logic [1:0] retry_cnt;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk_pll = ~clk_pll;

  aibcr3_str_align_seq #(
    .SYNC_STAGES (SYNC_STAGES),
    .TO_SHIFT    (TO_SHIFT)
  ) dut (
    .clk_pll       (clk_pll),
    .sync_rst      (sync_rst),
    .seq_en        (seq_en),
    .csr_rst_cyc   (csr_rst_cyc),
    .csr_timeout   (csr_timeout),
    .csr_max_retry (csr_max_retry),
    .dll_lock      (dll_lock),
    .code_valid    (code_valid),
    .dll_rst_n     (dll_rst_n),
    .lock_req      (lock_req),
    .align_done    (align_done),
    .align_fail    (align_fail),
    .retry_cnt     (retry_cnt),
    .seq_state     (seq_state)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State is tracked as "which phase, how long have we been in it".
  int       m_state = 0;
  int       m_age   = 0;   // clocks already spent in current phase
  int       m_zeros = 0;   // consecutive lock_s=0 clocks while locked
  int       m_retry = 0;
  int       m_hold  = 1;   // reset-hold length captured on DRST entry
  logic [2:0] m_hist = 3'b000; // dll_lock samples, [0] = most recent
  int       m_nxt;
  bit       m_ls;

  always @(posedge clk_pll) begin
    m_ls = m_hist[SYNC_STAGES-1];
    if (sync_rst) begin
      m_state = 0; m_age = 0; m_zeros = 0; m_retry = 0; m_hist = 3'b000;
    end else begin
      m_nxt = m_state;
      if (!seq_en) begin
        m_nxt   = 0;
        m_retry = 0;
      end else begin
        case (m_state)
          0: begin m_nxt = 1; m_hold = (csr_rst_cyc == 0) ? 1 : int'(csr_rst_cyc); end
          1: if (m_age + 1 >= m_hold) m_nxt = 2;
          2: m_nxt = 3;
          3: begin
            if (m_ls && code_valid) m_nxt = 4;
            else if (csr_timeout != 0 && ((m_age + 1) % 4096) == (int'(csr_timeout) << TO_SHIFT))
              m_nxt = 5;
          end
          4: begin
            if (!m_ls) begin
              m_zeros++;
              if (m_zeros >= 2) m_nxt = 5;
            end else m_zeros = 0;
          end
          5: begin
            if (m_retry < int'(csr_max_retry)) begin
              m_retry = (m_retry + 1 > 3) ? 3 : m_retry + 1;
              m_hold  = (csr_rst_cyc == 0) ? 1 : int'(csr_rst_cyc);
              m_nxt   = 1;
            end else m_nxt = 6;
          end
          default: m_nxt = m_state;
        endcase
      end
      if (m_nxt != m_state) begin m_age = 0; m_zeros = 0; end
      else m_age++;
      m_state = m_nxt;
      m_hist  = {m_hist[1:0], dll_lock};
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk_pll) begin
    #2;
    if (chk_en) begin
      chk("m_state",      int'(seq_state),  m_state);
      chk("m_dll_rst_n",  int'(dll_rst_n),  (m_state == 2 || m_state == 3 || m_state == 4) ? 1 : 0);
      chk("m_lock_req",   int'(lock_req),   (m_state == 2 || m_state == 3 || m_state == 4) ? 1 : 0);
      chk("m_align_done", int'(align_done), (m_state == 4) ? 1 : 0);
      chk("m_align_fail", int'(align_fail), (m_state == 6) ? 1 : 0);
      chk("m_retry_cnt",  int'(retry_cnt),  m_retry);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_state(input int st, input int limit, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < limit) begin
      @(negedge clk_pll);
      if (int'(seq_state) == st) begin ok = 1'b1; break; end
      n++;
    end
  endtask

  int n;
  int bad;
  bit ok;

  initial begin
    sync_rst = 1'b1; seq_en = 1'b0; csr_rst_cyc = 4'd3; csr_timeout = 8'd0;
    csr_max_retry = 2'd0; dll_lock = 1'b0; code_valid = 1'b0;
    repeat (3) @(negedge clk_pll);
    chk_en = 1'b1;
    chk("rst_state", int'(seq_state), 0);
    chk("rst_rstn",  int'(dll_rst_n), 0);
    chk("rst_req",   int'(lock_req), 0);
    chk("rst_done",  int'(align_done), 0);
    chk("rst_fail",  int'(align_fail), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    sync_rst = 1'b0;

    // Nominal lock
    seq_en = 1'b1;
    wait_state(1, 10, ok); chk("nom_drst_reach", int'(ok), 1);
    n = 0;
    while (seq_state == 3'd1 && dll_rst_n == 1'b0 && n < 40) begin n++; @(negedge clk_pll); end
    chk("nom_drst_len", n, 3);
    chk("nom_req_state", int'(seq_state), 2);
    chk("nom_req_rstn", int'(dll_rst_n), 1);
    repeat (5) @(negedge clk_pll);
    dll_lock = 1'b1; code_valid = 1'b1;
    n = 0;
    do begin @(negedge clk_pll); n++; end while (!align_done && n < 20);
    chk("nom_lock_lat", n, SYNC_STAGES + 1);
    chk("nom_retry", int'(retry_cnt), 0);

    // Glitch filter
    csr_max_retry = 2'd3;
    dll_lock = 1'b0; @(negedge clk_pll); dll_lock = 1'b1;
    bad = 0;
    repeat (6) begin @(negedge clk_pll); if (!align_done) bad++; end
    chk("glitch1_hold", bad, 0);
    dll_lock = 1'b0; repeat (2) @(negedge clk_pll); dll_lock = 1'b1;
    wait_state(5, 10, ok); chk("glitch2_retry", int'(ok), 1);
    @(negedge clk_pll);
    chk("glitch2_drst", int'(seq_state), 1);
    chk("glitch2_cnt", int'(retry_cnt), 1);
    wait_state(4, 40, ok); chk("glitch2_relock", int'(ok), 1);

    // Timeout and fail
    seq_en = 1'b0; @(negedge clk_pll);
    chk("abort_idle", int'(seq_state), 0);
    chk("abort_retry", int'(retry_cnt), 0);
    dll_lock = 1'b0; code_valid = 1'b0; csr_timeout = 8'd2; csr_max_retry = 2'd1;
    csr_rst_cyc = 4'd2; seq_en = 1'b1;
    wait_state(3, 30, ok); chk("to_wait_reach", int'(ok), 1);
    n = 0;
    while (seq_state == 3'd3 && n < 100) begin n++; @(negedge clk_pll); end
    chk("to_wait_len", n, 32);
    chk("to_retry_state", int'(seq_state), 5);
    @(negedge clk_pll);
    chk("to_retry_cnt", int'(retry_cnt), 1);
    wait_state(6, 200, ok); chk("to_fail_reach", int'(ok), 1);
    chk("to_fail_flag", int'(align_fail), 1);
    repeat (8) @(negedge clk_pll);
    chk("to_fail_sticky", int'(align_fail), 1);
    chk("to_fail_state", int'(seq_state), 6);
    seq_en = 1'b0; @(negedge clk_pll);
    chk("fail_abort_state", int'(seq_state), 0);
    chk("fail_abort_flag", int'(align_fail), 0);
    chk("fail_abort_retry", int'(retry_cnt), 0);

    // Lock exactly on the timeout cycle (limit 16)
    csr_timeout = 8'd1; csr_max_retry = 2'd3; seq_en = 1'b1;
    wait_state(3, 40, ok); chk("sim_wait_reach", int'(ok), 1);
    repeat (13) @(negedge clk_pll);
    dll_lock = 1'b1;
    repeat (2) @(negedge clk_pll);
    code_valid = 1'b1;
    @(negedge clk_pll);
    chk("sim_locked", int'(seq_state), 4);
    chk("sim_retry", int'(retry_cnt), 0);

    // Reset pulse in WAIT, then 1-clock DRST with csr_rst_cyc=0
    seq_en = 1'b0; dll_lock = 1'b0; code_valid = 1'b0; csr_timeout = 8'd0;
    csr_rst_cyc = 4'd0; @(negedge clk_pll);
    seq_en = 1'b1;
    wait_state(3, 40, ok); chk("rw_wait_reach", int'(ok), 1);
    sync_rst = 1'b1; @(negedge clk_pll);
    chk("rw_state", int'(seq_state), 0);
    chk("rw_rstn",  int'(dll_rst_n), 0);
    chk("rw_req",   int'(lock_req), 0);
    chk("rw_done",  int'(align_done), 0);
    chk("rw_fail",  int'(align_fail), 0);
    sync_rst = 1'b0;
    @(negedge clk_pll); chk("z_drst", int'(seq_state), 1);
    @(negedge clk_pll); chk("z_req", int'(seq_state), 2);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_pll);
      sync_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 79) == 0) seq_en = ~seq_en;
      else if (!seq_en && $urandom_range(0, 3) == 0) seq_en = 1'b1;
      if ($urandom_range(0, 7) == 0) dll_lock = ~dll_lock;
      code_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        csr_rst_cyc   = 4'($urandom_range(0, 5));
        csr_timeout   = 8'($urandom_range(0, 3));
        csr_max_retry = 2'($urandom_range(0, 3));
      end
    end
    sync_rst = 1'b0;
    @(negedge clk_pll);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aibcr3_str_align_seq.md
AIBCR3_STR_ALIGN_SEQ -- requirements
Module: aibcr3_str_align_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: dll_lock synchronizer depth (range 2-3).
REQ-002 Parameter TO_SHIFT, default 4: lock-timeout unit is 2^TO_SHIFT clocks.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_pll  in  1  strobe-DLL reference clock; sole clock.
REQ-005 sync_rst  in  1  synchronous, active-high reset.
REQ-006 seq_en  in  1  level; 1 = run the alignment sequence, 0 = return to IDLE.
REQ-007 csr_rst_cyc  in  4  DLL reset hold length in clocks; 0 is treated as 1.
REQ-008 csr_timeout  in  8  lock wait limit in 2^TO_SHIFT-clock units; 0 = wait forever.
REQ-009 csr_max_retry  in  2  allowed relock attempts after the first.
REQ-010 dll_lock  in  1  asynchronous DLL lock status.
REQ-011 code_valid  in  1  DLL gray code valid (gate_shf MSB), synchronous.
REQ-012 dll_rst_n  out  1  active-low DLL/phase-detector reset.
REQ-013 lock_req  out  1  lock request to the DLL.
REQ-014 align_done  out  1  alignment achieved.
REQ-015 align_fail  out  1  retries exhausted; sticky until reset or seq_en=0.
REQ-016 retry_cnt  out  2  relock attempts used.
REQ-017 seq_state  out  3  current FSM state encoding.

Function
REQ-018 dll_lock SHALL pass through a SYNC_STAGES flop synchronizer; lock_s denotes its output.
REQ-019 FSM states SHALL be IDLE=0, DRST=1, REQ=2, WAIT=3, LOCKED=4, RETRY=5, FAIL=6, all registered.
REQ-020 IDLE: dll_rst_n=0, lock_req=0; seq_en=1 SHALL go to DRST on the next clock, loading the hold counter with max(csr_rst_cyc,1).
REQ-021 DRST: dll_rst_n=0; the counter SHALL decrement each clock and go to REQ when it reaches 1 (hold = N clocks exactly).
REQ-022 REQ: dll_rst_n=1, lock_req=1; SHALL go to WAIT after exactly one clock and clear the 12-bit timeout counter.
REQ-023 WAIT: lock_req=1; lock_s=1 AND code_valid=1 in the same cycle SHALL go to LOCKED.
REQ-024 In WAIT, the timeout counter SHALL increment each clock; when it equals csr_timeout<<TO_SHIFT (csr_timeout!=0), the FSM SHALL go to RETRY.
REQ-025 Lock and timeout in the same cycle: lock SHALL win.
REQ-026 LOCKED: align_done=1, lock_req=1; lock_s=0 for 2 consecutive clocks SHALL go to RETRY; a single-cycle drop is ignored.
REQ-027 RETRY, when retry_cnt < csr_max_retry: SHALL increment retry_cnt and go to DRST, reloading the hold counter.
REQ-028 RETRY, otherwise: SHALL go to FAIL.
REQ-029 RETRY lasts exactly one clock, with dll_rst_n=0 and lock_req=0.
REQ-030 FAIL: align_fail=1, dll_rst_n=0, lock_req=0; the FSM SHALL remain there until seq_en=0.
REQ-031 seq_en=0 in any state SHALL go to IDLE on the next clock and clear retry_cnt, align_done and align_fail.
REQ-032 retry_cnt SHALL saturate at 3 and never wrap.
REQ-033 All outputs SHALL be registered, with one-clock latency from the state decision.

Reset
REQ-034 sync_rst=1 SHALL, at the next clk_pll edge, force the following: state IDLE, dll_rst_n=0, lock_req=0, align_done=0, align_fail=0, retry_cnt=0, seq_state=0, all counters 0, synchronizer flops 0.
REQ-035 Reset asserted mid-sequence (any state) SHALL take priority over every transition.
REQ-036 After reset release, the FSM SHALL restart from IDLE with no memory of prior retries.

Structure
REQ-037 State encoding, the timeout width constant (12) and the retry width SHALL live in the shared package aibcr3_str_align_pkg.
REQ-038 The synchronizer SHALL be a separate sub-module, aibcr3_sync_bit (parameterized depth); all else is flat.

Verification
REQ-039 Nominal lock: csr_rst_cyc=3, seq_en=1, then dll_lock=1 and code_valid=1, 5 clocks after REQ. Required: dll_rst_n low for exactly 3 clocks; align_done=1 after synchronizer delay + 1; retry_cnt=0.
REQ-040 Timeout and fail: csr_timeout=2, TO_SHIFT=4, csr_max_retry=1, dll_lock=0. Required: RETRY after 32 WAIT clocks; retry_cnt=1; second timeout gives FAIL with align_fail=1 held.
REQ-041 Glitch filter: in LOCKED, a 1-clock dll_lock drop leaves align_done=1; a 2-clock drop gives RETRY, retry_cnt+1, and DRST re-entered.
REQ-042 Simultaneous events: lock_s/code_valid rising on the exact timeout cycle. Required: LOCKED, not RETRY.
REQ-043 Reset and seq_en abort: sync_rst pulse in WAIT, and seq_en=0 in FAIL. Required: IDLE next clock with all outputs at reset values; csr_rst_cyc=0 gives a 1-clock DRST.
